// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - P7 instruction-fetch sequencer: PC, single-outstanding imem
// requests, one-entry output buffer and exception/eret/branch redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    input  logic        i_exc_req,
    input  logic        i_eret,
    input  logic [31:0] i_epc,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic [31:0] i_d_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_f_valid,
    output logic [31:0] o_f_pc,
    output logic [31:0] o_f_instr,
    output logic        o_f_adel
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fpc;
    logic        r_pending;
    logic [31:0] r_pend_target;
    logic        r_f_valid;
    logic [31:0] r_f_pc;
    logic [31:0] r_f_instr;
    logic        r_f_adel;

    logic        w_pc_legal;
    logic        w_buf_free;
    logic        w_consume;
    logic        w_fire;
    logic        w_flush;
    logic [31:0] w_flush_pc;
    logic        w_branch;
    logic        w_slot_granted;

    assign w_pc_legal = (r_pc[1:0] == 2'b00) && (r_pc >= IM_LO) && (r_pc <= IM_HI);
    assign w_consume  = r_f_valid & ~i_stall;
    assign w_buf_free = ~r_f_valid | ~i_stall;
    // Gated by reset so the request drops the instant reset asserts.
    assign o_imem_req  = i_reset_n & (r_state == S_REQ) & w_pc_legal & w_buf_free;
    assign o_imem_addr = r_pc;
    assign w_fire      = o_imem_req & i_imem_gnt;

    assign w_flush    = i_exc_req | i_eret;
    assign w_flush_pc = i_exc_req ? EXC_VECTOR : i_epc;
    assign w_branch   = i_br_taken & ~w_flush;
    // Delay slot (d_pc+4) is already past us, or is being granted right now.
    assign w_slot_granted = (r_pc == i_d_pc + 32'd8) ||
                            (w_fire && (r_pc == i_d_pc + 32'd4));

    assign o_f_valid = r_f_valid;
    assign o_f_pc    = r_f_pc;
    assign o_f_instr = r_f_instr;
    assign o_f_adel  = r_f_adel;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_fpc         <= 32'd0;
            r_pending     <= 1'b0;
            r_pend_target <= 32'd0;
            r_f_valid     <= 1'b0;
            r_f_pc        <= 32'd0;
            r_f_instr     <= 32'd0;
            r_f_adel      <= 1'b0;
        end else begin
            if (w_consume) begin
                r_f_valid <= 1'b0;
            end

            case (r_state)
                S_REQ: begin
                    if (w_fire) begin
                        r_fpc     <= r_pc;
                        r_pc      <= r_pending ? r_pend_target : r_pc + 32'd4;
                        r_pending <= 1'b0;
                        r_state   <= S_WAIT;
                    end else if (!w_pc_legal && w_buf_free) begin
                        r_f_valid <= 1'b1;
                        r_f_pc    <= r_pc;
                        r_f_instr <= 32'd0;
                        r_f_adel  <= 1'b1;
                        r_state   <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        r_f_valid <= 1'b1;
                        r_f_pc    <= r_fpc;
                        r_f_instr <= i_imem_rdata;
                        r_f_adel  <= 1'b0;
                        r_state   <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (i_imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                end
            endcase

            // Redirects override the normal sequencing above.
            if (w_flush) begin
                r_pc      <= w_flush_pc;
                r_f_valid <= 1'b0;
                r_pending <= 1'b0;
                if ((r_state == S_WAIT && !i_imem_rvalid) || w_fire) begin
                    r_state <= S_DRAIN;
                end else begin
                    r_state <= S_REQ;
                end
            end else if (w_branch) begin
                if (w_slot_granted) begin
                    r_pc <= i_br_target;
                end else begin
                    r_pending     <= 1'b1;
                    r_pend_target <= i_br_target;
                end
            end
        end
    end

endmodule
